video_tpg: RTL and testbench
============================

# video_tpg

Video timing and test-pattern generator: the transmitting end of the parallel video interface (vsync/hsync/de + 10-bit RGB) that the scaler consumes. It produces complete frames with programmable blanking and one of four selectable patterns. Its outputs connect directly to the scaler inputs, both in simulation benches and as an on-chip source for bring-up.

## Interface
Parameters:
- HACT, 10 — active pixels per line (≥ 8)
- VACT, 4 — active lines per frame
- HFP / HSW / HBP, 2 / 2 / 2 — horizontal front porch / sync width / back porch, in pixels (each ≥ 1)
- VFP / VSW / VBP, 1 / 1 / 1 — vertical front porch / sync / back porch, in lines (each ≥ 1)
- RAMP_STEP, 64 — per-pixel / per-line increment for the ramp patterns

Ports:
- clk in 1 — sole clock
- rstn in 1 — synchronous, active-low reset
- i_en in 1 — run request; sampled per frame
- i_pattern in 2 — 0 colour bars, 1 horizontal ramp, 2 vertical ramp, 3 checkerboard
- o_vsync out 1 — active-high vertical sync
- o_hsync out 1 — active-high horizontal sync
- o_de out 1 — active-video enable
- o_r_data / o_g_data / o_b_data out 10 each — pixel data; 0 when o_de = 0
- o_frame_start out 1 — one-cycle pulse coincident with the first o_de of each frame
- o_frame_cnt out 16 — completed-frame count, wraps at 65535 → 0

## Operation
- HTOTAL = HACT+HFP+HSW+HBP (16 by default); VTOTAL = VACT+VFP+VSW+VBP (7); 12-bit h/v counters.
- Line order: active, front porch, sync, back porch. hsync is high for h ∈ [HACT+HFP, HACT+HFP+HSW). Frame order is the same in lines; vsync is high for all HTOTAL cycles of each line with v ∈ [VACT+VFP, VACT+VFP+VSW).
- de = (h < HACT) && (v < VACT).
- FSM IDLE/RUN. IDLE → RUN when i_en = 1: counters load h = v = 0. In RUN, h wraps at HTOTAL−1 and v increments; at the last cycle of the frame (h = HTOTAL−1, v = VTOTAL−1), o_frame_cnt increments, then the FSM goes to RUN (new frame, counters to 0) if i_en = 1, else to IDLE. Dropping i_en mid-frame never truncates the frame.
- i_pattern is latched at every frame-start load. Changes mid-frame are ignored until the next frame.
- Colour bars: bar = (h·8)/HACT. Bars 0–7 are white, yellow, cyan, green, magenta, red, blue, black, with each component either 1023 or 0.
- H ramp: R = G = B = (h·RAMP_STEP) mod 1024. V ramp: the same with v.
- Checker: R = G = B = 1023 if h[0]^v[0]^o_frame_cnt[0], else 0.
- IDLE: syncs, de and data are held at 0.

## Timing
- Reset (rstn = 0 at an edge): state IDLE, counters 0, all outputs 0 (including o_frame_cnt) after that edge. This applies equally mid-frame.
- All outputs are registered, one cycle behind the counters. If i_en is high at edge N while in IDLE, the first o_de = 1 and o_frame_start appear after edge N+1.
- Frame period is HTOTAL·VTOTAL cycles (112 by default), back-to-back with no idle gap while i_en stays high.
- o_frame_cnt updates at the edge following the final blanking cycle of a frame.

## Structure
- Package video_tpg_pkg holds:
  - the pattern_e enum (BARS, HRAMP, VRAMP, CHECK);
  - the state_e enum (IDLE, RUN);
  - an 8-entry 30-bit colour-bar constant array.
- Sub-module video_timing_gen holds the h/v counters and the sync/de decode, with a frame-load input and a last-pixel output.
- video_tpg itself holds the FSM, pattern latch, pixel mux, output registers and frame counter.

## Test plan
- Reset/idle: hold rstn low, then i_en = 0 for 200 cycles → every output stays 0.
- Timing with defaults and i_en = 1:
  - each line has 10 o_de cycles, then hsync high for 2 cycles starting 2 cycles after the last de, with a 16-cycle period;
  - each frame has 4 active lines, then vsync high for exactly 16 cycles on line 5;
  - o_frame_start pulses every 112 cycles.
- Colour bars: pixels h0..9 = white, white, yellow, cyan, green, magenta, magenta, red, blue, black (e.g. yellow = R 1023, G 1023, B 0).
- Ramps:
  - pattern 1 → pixels 0, 64, …, 576 on every line;
  - pattern 2 → lines of 0, 64, 128, 192.
- Pattern switch and checker:
  - switching 0 → 3 mid-frame takes effect only at the next o_frame_start;
  - checker pixel (0,0) is black when o_frame_cnt is even and white when it is odd.
- Stop and reset:
  - dropping i_en on line 1 → the frame completes, o_frame_cnt goes 0 → 1, then idle;
  - rstn low mid-line → all outputs 0 after the next edge, and o_frame_cnt = 0.

Source files
------------

// File: rtl/video_tpg_pkg.sv
// Shared types and constants for the video test-pattern generator.
//   pattern_e : selectable test patterns
//   state_e   : top-level run/idle state
//   BAR_RGB   : colour-bar table, {R,G,B} with 10 bits per component
package video_tpg_pkg;

   typedef enum logic [1:0] {
      BARS  = 2'd0,
      HRAMP = 2'd1,
      VRAMP = 2'd2,
      CHECK = 2'd3
   } pattern_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [9:0] C_ON  = 10'h3ff;
   localparam logic [9:0] C_OFF = 10'h000;

   // white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [29:0] BAR_RGB [8] = '{
      {C_ON,  C_ON,  C_ON },
      {C_ON,  C_ON,  C_OFF},
      {C_OFF, C_ON,  C_ON },
      {C_OFF, C_ON,  C_OFF},
      {C_ON,  C_OFF, C_ON },
      {C_ON,  C_OFF, C_OFF},
      {C_OFF, C_OFF, C_ON },
      {C_OFF, C_OFF, C_OFF}
   };

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical position counters with sync and active-video decode.
//   clk, rstn : clock, synchronous active-low reset
//   load      : restart the frame (h = v = 0) at the next edge
//   adv       : advance one pixel per cycle
//   h, v      : current pixel position
//   hsync, vsync, de : decoded from the current position (unregistered)
//   last_pix  : current position is the final blanking pixel of the frame
module video_timing_gen #(
   parameter int HACT = 10,
   parameter int VACT = 4,
   parameter int HFP  = 2,
   parameter int HSW  = 2,
   parameter int HBP  = 2,
   parameter int VFP  = 1,
   parameter int VSW  = 1,
   parameter int VBP  = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        load,
   input  logic        adv,
   output logic [11:0] h,
   output logic [11:0] v,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        last_pix
);

   localparam int HTOTAL = HACT + HFP + HSW + HBP;
   localparam int VTOTAL = VACT + VFP + VSW + VBP;

   localparam logic [11:0] H_LAST = 12'(HTOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(VTOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(HACT);
   localparam logic [11:0] V_ACT  = 12'(VACT);
   localparam logic [11:0] H_SS   = 12'(HACT + HFP);
   localparam logic [11:0] H_SE   = 12'(HACT + HFP + HSW);
   localparam logic [11:0] V_SS   = 12'(VACT + VFP);
   localparam logic [11:0] V_SE   = 12'(VACT + VFP + VSW);

   logic [11:0] h_q;
   logic [11:0] v_q;

   always_ff @(posedge clk) begin
      if (!rstn || load) begin
         h_q <= '0;
         v_q <= '0;
      end else if (adv) begin
         if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? '0 : v_q + 12'd1;
         end else begin
            h_q <= h_q + 12'd1;
         end
      end
   end

   assign h        = h_q;
   assign v        = v_q;
   assign hsync    = (h_q >= H_SS) && (h_q < H_SE);
   assign vsync    = (v_q >= V_SS) && (v_q < V_SE);
   assign de       = (h_q < H_ACT) && (v_q < V_ACT);
   assign last_pix = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/video_tpg.sv
// Video timing and test-pattern generator (parallel vsync/hsync/de + 10-bit RGB).
//   clk, rstn      : clock, synchronous active-low reset
//   i_en           : run request, sampled at frame boundaries
//   i_pattern      : 0 bars, 1 h-ramp, 2 v-ramp, 3 checker; latched per frame
//   o_vsync/o_hsync/o_de : registered timing outputs
//   o_r/g/b_data   : registered pixel data, 0 outside active video
//   o_frame_start  : pulse with the first o_de of each frame
//   o_frame_cnt    : completed-frame count
//
// state | meaning
// IDLE  | outputs held at 0, waiting for i_en
// RUN   | counters advancing; frame boundary decides RUN again or IDLE
module video_tpg #(
   parameter int HACT      = 10,
   parameter int VACT      = 4,
   parameter int HFP       = 2,
   parameter int HSW       = 2,
   parameter int HBP       = 2,
   parameter int VFP       = 1,
   parameter int VSW       = 1,
   parameter int VBP       = 1,
   parameter int RAMP_STEP = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_en,
   input  logic [1:0]  i_pattern,
   output logic        o_vsync,
   output logic        o_hsync,
   output logic        o_de,
   output logic [9:0]  o_r_data,
   output logic [9:0]  o_g_data,
   output logic [9:0]  o_b_data,
   output logic        o_frame_start,
   output logic [15:0] o_frame_cnt
);

   import video_tpg_pkg::*;

   state_e      state_q, state_d;
   pattern_e    pat_q;
   logic        frame_load, adv;
   logic [11:0] h, v;
   logic        hsync, vsync, de, last_pix;
   logic [2:0]  bar_idx;
   logic [9:0]  ramp_h, ramp_v;
   logic        chk;
   logic [29:0] pix;

   video_timing_gen #(
      .HACT(HACT), .VACT(VACT),
      .HFP(HFP), .HSW(HSW), .HBP(HBP),
      .VFP(VFP), .VSW(VSW), .VBP(VBP)
   ) u_timing (
      .clk      (clk),
      .rstn     (rstn),
      .load     (frame_load),
      .adv      (adv),
      .h        (h),
      .v        (v),
      .hsync    (hsync),
      .vsync    (vsync),
      .de       (de),
      .last_pix (last_pix)
   );

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // A running frame always reaches its last pixel; i_en only matters there.
   always_comb begin
      state_d    = state_q;
      frame_load = 1'b0;
      adv        = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_en) begin
               state_d    = RUN;
               frame_load = 1'b1;
            end
         end
         RUN: begin
            adv = 1'b1;
            if (last_pix) begin
               frame_load = i_en;
               state_d    = i_en ? RUN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Checker phase uses the count already advanced at the previous frame end.
   always_comb begin
      bar_idx = 3'((32'(h) * 8) / HACT);
      ramp_h  = 10'(32'(h) * RAMP_STEP);
      ramp_v  = 10'(32'(v) * RAMP_STEP);
      chk     = h[0] ^ v[0] ^ o_frame_cnt[0];
      pix     = '0;
      case (pat_q)
         BARS:    pix = BAR_RGB[bar_idx];
         HRAMP:   pix = {3{ramp_h}};
         VRAMP:   pix = {3{ramp_v}};
         CHECK:   pix = chk ? {3{C_ON}} : '0;
         default: pix = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pat_q         <= BARS;
         o_vsync       <= 1'b0;
         o_hsync       <= 1'b0;
         o_de          <= 1'b0;
         o_frame_start <= 1'b0;
         o_r_data      <= '0;
         o_g_data      <= '0;
         o_b_data      <= '0;
         o_frame_cnt   <= '0;
      end else begin
         if (frame_load) pat_q <= pattern_e'(i_pattern);
         if (state_q == RUN) begin
            o_vsync       <= vsync;
            o_hsync       <= hsync;
            o_de          <= de;
            o_frame_start <= de && (h == 12'd0) && (v == 12'd0);
            {o_r_data, o_g_data, o_b_data} <= de ? pix : '0;
            if (last_pix) o_frame_cnt <= o_frame_cnt + 16'd1;
         end else begin
            o_vsync       <= 1'b0;
            o_hsync       <= 1'b0;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_r_data      <= '0;
            o_g_data      <= '0;
            o_b_data      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_video_tpg.sv
module tb_video_tpg;

   logic        clk = 1'b0;
   logic        rstn;
   logic        i_en;
   logic [1:0]  i_pattern;
   logic        o_vsync, o_hsync, o_de, o_frame_start;
   logic [9:0]  o_r_data, o_g_data, o_b_data;
   logic [15:0] o_frame_cnt;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [9:0]  r;
      logic [9:0]  g;
      logic [9:0]  b;
      logic        fs;
      logic [15:0] cnt;
   } pix_t;

   pix_t exp_q[$];
   logic track  = 1'b0;
   logic active = 1'b0;
   int   pos    = 0;

   // colour bars per pixel h0..9: W W Y C G M M R B K
   logic r_on [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic g_on [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic b_on [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   always #5 clk = ~clk;

   video_tpg dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_en          (i_en),
      .i_pattern     (i_pattern),
      .o_vsync       (o_vsync),
      .o_hsync       (o_hsync),
      .o_de          (o_de),
      .o_r_data      (o_r_data),
      .o_g_data      (o_g_data),
      .o_b_data      (o_b_data),
      .o_frame_start (o_frame_start),
      .o_frame_cnt   (o_frame_cnt)
   );

   task automatic push_frame(input int pat, input int cnt);
      pix_t e;
      logic [9:0] val;
      for (int v = 0; v < 4; v++) begin
         for (int h = 0; h < 10; h++) begin
            e.fs  = (h == 0) && (v == 0);
            e.cnt = 16'(cnt);
            val   = '0;
            case (pat)
               0: val = '0;
               1: val = 10'(h * 64);
               2: val = 10'(v * 64);
               default: val = (((h ^ v ^ cnt) & 1) != 0) ? 10'h3ff : 10'h000;
            endcase
            if (pat == 0) begin
               e.r = r_on[h] ? 10'h3ff : 10'h000;
               e.g = g_on[h] ? 10'h3ff : 10'h000;
               e.b = b_on[h] ? 10'h3ff : 10'h000;
            end else begin
               e.r = val;
               e.g = val;
               e.b = val;
            end
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_fs(input string name);
      int k;
      k = 0;
      step(1);
      while (!o_frame_start && k < 300) begin
         step(1);
         k++;
      end
      tests++;
      if (!o_frame_start) begin
         fails++;
         $display("FAIL %s: no o_frame_start within 300 cycles", name);
      end
   endtask

   function automatic logic all_zero();
      return ({o_vsync, o_hsync, o_de, o_frame_start,
               o_r_data, o_g_data, o_b_data, o_frame_cnt} == '0);
   endfunction

   // Scoreboard: pixel contents popped whenever the DUT shows active video,
   // plus a position model of line/frame timing anchored on o_frame_start.
   always @(negedge clk) begin : monitor
      pix_t e;
      int   hh, vv;
      logic xde, xhs, xvs;
      if (o_de) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_de: got de=1 cnt=%0d, want no active pixel", o_frame_cnt);
         end else begin
            e = exp_q.pop_front();
            if ({o_r_data, o_g_data, o_b_data, o_frame_start, o_frame_cnt} !==
                {e.r, e.g, e.b, e.fs, e.cnt}) begin
               fails++;
               $display("FAIL pixel: got r=%0d g=%0d b=%0d fs=%0d cnt=%0d want r=%0d g=%0d b=%0d fs=%0d cnt=%0d",
                        o_r_data, o_g_data, o_b_data, o_frame_start, o_frame_cnt,
                        e.r, e.g, e.b, e.fs, e.cnt);
            end
         end
      end
      if (track) begin
         if (o_frame_start) begin
            if (active) begin
               tests++;
               if (pos != 111) begin
                  fails++;
                  $display("FAIL frame_period: got %0d cycles, want 112", pos + 1);
               end
            end
            pos    = 0;
            active = 1'b1;
         end else if (active) begin
            pos++;
            if (pos == 112) active = 1'b0;
         end
         if (active) begin
            hh  = pos % 16;
            vv  = pos / 16;
            xde = (hh < 10) && (vv < 4);
            xhs = (hh >= 12) && (hh < 14);
            xvs = (vv == 5);
            tests++;
            if (o_de !== xde || o_hsync !== xhs || o_vsync !== xvs ||
                o_frame_start !== (pos == 0) ||
                (!xde && {o_r_data, o_g_data, o_b_data} !== 30'd0)) begin
               fails++;
               $display("FAIL timing h=%0d v=%0d: got de=%0d hs=%0d vs=%0d fs=%0d rgb=%0d/%0d/%0d want de=%0d hs=%0d vs=%0d fs=%0d",
                        hh, vv, o_de, o_hsync, o_vsync, o_frame_start,
                        o_r_data, o_g_data, o_b_data, xde, xhs, xvs, (pos == 0));
            end
         end
      end else begin
         active = 1'b0;
      end
   end

   initial begin
      int bad;
      rstn      = 1'b0;
      i_en      = 1'b0;
      i_pattern = 2'd0;
      step(5);
      tests++;
      if (!all_zero()) begin
         fails++;
         $display("FAIL reset_state: got de=%0d hs=%0d vs=%0d cnt=%0d, want all 0",
                  o_de, o_hsync, o_vsync, o_frame_cnt);
      end

      rstn = 1'b1;
      bad  = 0;
      repeat (200) begin
         step(1);
         if (!all_zero()) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL idle_zero: got %0d non-zero cycles, want 0", bad);
      end

      // Frames 0..4: bars, checker (odd), h-ramp, v-ramp, checker (even)
      push_frame(0, 0);
      push_frame(3, 1);
      push_frame(1, 2);
      push_frame(2, 3);
      push_frame(3, 4);
      track = 1'b1;
      i_en  = 1'b1;
      wait_fs("frame0");
      step(20);
      i_pattern = 2'd3;
      wait_fs("frame1");
      step(20);
      i_pattern = 2'd1;
      wait_fs("frame2");
      step(20);
      i_pattern = 2'd2;
      wait_fs("frame3");
      step(20);
      i_pattern = 2'd3;
      wait_fs("frame4");
      step(20);
      i_en = 1'b0;
      tests++;
      if (o_frame_cnt !== 16'd4) begin
         fails++;
         $display("FAIL cnt_mid_frame4: got %0d, want 4", o_frame_cnt);
      end

      step(150);
      tests++;
      if (o_frame_cnt !== 16'd5) begin
         fails++;
         $display("FAIL cnt_after_stop: got %0d, want 5", o_frame_cnt);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pixels_left: got %0d unconsumed, want 0", exp_q.size());
      end
      tests++;
      if ({o_vsync, o_hsync, o_de, o_frame_start, o_r_data, o_g_data, o_b_data} != '0) begin
         fails++;
         $display("FAIL idle_after_stop: got de=%0d hs=%0d vs=%0d, want 0",
                  o_de, o_hsync, o_vsync);
      end

      // Reset in the middle of an active line
      i_pattern = 2'd0;
      push_frame(0, 5);
      i_en = 1'b1;
      wait_fs("frame5");
      step(4);
      track = 1'b0;
      rstn  = 1'b0;
      i_en  = 1'b0;
      step(1);
      tests++;
      if (!all_zero()) begin
         fails++;
         $display("FAIL reset_mid_line: got de=%0d r=%0d cnt=%0d, want all 0",
                  o_de, o_r_data, o_frame_cnt);
      end
      exp_q.delete();
      rstn = 1'b1;
      step(20);
      tests++;
      if (!all_zero()) begin
         fails++;
         $display("FAIL idle_after_reset: got de=%0d cnt=%0d, want all 0", o_de, o_frame_cnt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
